loop_sched: RTL

LOOP_SCHED -- requirements
Module: loop_sched

---
 rtl/galvano_pkg.sv | 22 ++
 rtl/loop_tick.sv | 31 +++
 rtl/loop_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/galvano_pkg.sv
// galvano_pkg: shared definitions for the galvo control-loop scheduler.
//   - default loop period and wait-state timeout (in clk_ref cycles)
//   - FSM state encoding used by loop_sched
//   - saturating 8-bit increment helper for event counters
package galvano_pkg;

   localparam int PERIOD_CYC_DEF  = 200;   // 100 kHz loop at 20 MHz
   localparam int TIMEOUT_CYC_DEF = 64;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ADC_START = 3'd1;
   localparam logic [2:0] ST_ADC_WAIT  = 3'd2;
   localparam logic [2:0] ST_PID_START = 3'd3;
   localparam logic [2:0] ST_PID_WAIT  = 3'd4;
   localparam logic [2:0] ST_DAC_START = 3'd5;
   localparam logic [2:0] ST_DAC_WAIT  = 3'd6;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/loop_tick.sv
// loop_tick: free-running period generator.
//   clk_ref : loop clock
//   sys_rst : asynchronous active-high reset
//   tick    : one-cycle pulse, registered, high in the cycle after the
//             counter wraps; first pulse PERIOD_CYC cycles after reset release
module loop_tick
   import galvano_pkg::*;
#(
   parameter int PERIOD_CYC = PERIOD_CYC_DEF
) (
   input  logic clk_ref,
   input  logic sys_rst,
   output logic tick
);

   localparam int            CW   = $clog2(PERIOD_CYC);
   localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_ref or posedge sys_rst) begin
      if (sys_rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (cnt == LAST);
         cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/loop_sched.sv
// loop_sched: sequences one galvo control-loop iteration per period tick:
// start ADCs, wait for both axis samples, start PID, wait for it, start both
// DAC writes, wait for both. Every wait state is bounded by TIMEOUT_CYC;
// expiry raises a sticky fault that blocks new iterations until fault_clr.
// Ports:
//   clk_ref, sys_rst            : clock, async active-high reset
//   enable                      : allow new iterations at tick
//   fault_clr                   : pulse, clears fault and overrun_cnt
//   adc_start / pid_start / dac_start : one-cycle start pulses
//   adc_{x,y}_dvalid, adc_{x,y}_dout  : per-axis samples
//   pos_x, pos_y                : samples latched during ADC_WAIT
//   pid_done, dac_{x,y}_done    : completion strobes
//   busy                        : FSM not idle
//   fault                       : sticky wait-timeout flag
//   overrun_cnt                 : ticks dropped while busy, saturating
module loop_sched
   import galvano_pkg::*;
#(
   parameter int PERIOD_CYC  = PERIOD_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk_ref,
   input  logic        sys_rst,
   input  logic        enable,
   input  logic        fault_clr,
   output logic        adc_start,
   input  logic        adc_x_dvalid,
   input  logic        adc_y_dvalid,
   input  logic [15:0] adc_x_dout,
   input  logic [15:0] adc_y_dout,
   output logic [15:0] pos_x,
   output logic [15:0] pos_y,
   output logic        pid_start,
   input  logic        pid_done,
   output logic        dac_start,
   input  logic        dac_x_done,
   input  logic        dac_y_done,
   output logic        busy,
   output logic        fault,
   output logic [7:0]  overrun_cnt
);

   localparam logic [7:0] WLAST = 8'(TIMEOUT_CYC - 1);

   logic       tick;
   logic [2:0] state, state_nx;
   logic [7:0] wcnt;
   logic       got_x, got_y;
   logic       in_wait, exit_ok, timeout;

   loop_tick #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
      .clk_ref (clk_ref),
      .sys_rst (sys_rst),
      .tick    (tick)
   );

   // Exit condition includes this cycle's strobe so the next start pulse
   // comes one cycle after the last required strobe.
   always_comb begin
      exit_ok = 1'b0;
      case (state)
         ST_ADC_WAIT: exit_ok = (got_x | adc_x_dvalid) & (got_y | adc_y_dvalid);
         ST_PID_WAIT: exit_ok = pid_done;
         ST_DAC_WAIT: exit_ok = (got_x | dac_x_done) & (got_y | dac_y_done);
         default:     exit_ok = 1'b0;
      endcase
   end

   assign in_wait = (state == ST_ADC_WAIT) || (state == ST_PID_WAIT) ||
                    (state == ST_DAC_WAIT);
   // exit wins over a simultaneous timeout
   assign timeout = in_wait && !exit_ok && (wcnt == WLAST);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:      if (tick && enable && !fault) state_nx = ST_ADC_START;
         ST_ADC_START: state_nx = ST_ADC_WAIT;
         ST_ADC_WAIT:  if (exit_ok) state_nx = ST_PID_START;
                       else if (timeout) state_nx = ST_IDLE;
         ST_PID_START: state_nx = ST_PID_WAIT;
         ST_PID_WAIT:  if (exit_ok) state_nx = ST_DAC_START;
                       else if (timeout) state_nx = ST_IDLE;
         ST_DAC_START: state_nx = ST_DAC_WAIT;
         ST_DAC_WAIT:  if (exit_ok || timeout) state_nx = ST_IDLE;
         default:      state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_ref or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= ST_IDLE;
         wcnt        <= 8'd0;
         got_x       <= 1'b0;
         got_y       <= 1'b0;
         pos_x       <= 16'h0000;
         pos_y       <= 16'h0000;
         fault       <= 1'b0;
         overrun_cnt <= 8'd0;
      end else begin
         state <= state_nx;
         // counter is zero outside wait states, so it is clear on entry
         wcnt  <= (in_wait && state_nx == state) ? wcnt + 8'd1 : 8'd0;

         // got/done flags share storage; the PID states in between clear them
         if (state == ST_ADC_WAIT) begin
            got_x <= got_x | adc_x_dvalid;
            got_y <= got_y | adc_y_dvalid;
         end else if (state == ST_DAC_WAIT) begin
            got_x <= got_x | dac_x_done;
            got_y <= got_y | dac_y_done;
         end else begin
            got_x <= 1'b0;
            got_y <= 1'b0;
         end

         if (state == ST_ADC_WAIT && adc_x_dvalid) pos_x <= adc_x_dout;
         if (state == ST_ADC_WAIT && adc_y_dvalid) pos_y <= adc_y_dout;

         // a fresh timeout beats a simultaneous clear
         if (timeout)        fault <= 1'b1;
         else if (fault_clr) fault <= 1'b0;

         if (fault_clr)                        overrun_cnt <= 8'd0;
         else if (tick && state != ST_IDLE)    overrun_cnt <= sat_inc8(overrun_cnt);
      end
   end

   assign adc_start = (state == ST_ADC_START);
   assign pid_start = (state == ST_PID_START);
   assign dac_start = (state == ST_DAC_START);
   assign busy      = (state != ST_IDLE);

endmodule
